// File: rtl/clb_cfg_pkg.sv
// -----------------------------------------------------------------------------
// clb_cfg_pkg
// Shared definitions for the CLB configuration path. The loader and the CLB
// tile both use the field offsets below. Contents:
//   cfg_state_t        loader FSM states
//   CFG_W              bits per CLB configuration frame (without parity)
//   *_LSB              bit offset of every field inside a frame
//   RESET_FRAME        tile configuration applied while reset is active
//   SYNC_WORD_DEFAULT  default preamble byte
// -----------------------------------------------------------------------------
package clb_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_LEN,
    ST_FRAME,
    ST_DONE,
    ST_ERROR
  } cfg_state_t;

  localparam int CFG_W = 37;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hB7;

  // Frame layout, MSB first on the wire.
  localparam int MEM_LSB          = 21;  // [36:21] LUT contents
  localparam int MEM_W            = 16;
  localparam int COMBOPTION_LSB   = 19;  // [20:19]
  localparam int MUX2_SELECT_LSB  = 17;  // [18:17]
  localparam int MUX3_SELECT_LSB  = 15;  // [16:15]
  localparam int MUX4_SELECT_LSB  = 13;  // [14:13]
  localparam int MUX5_SELECT_LSB  = 11;  // [12:11]
  localparam int MUX6_SELECT_LSB  = 9;   // [10:9]
  localparam int SELECT_W         = 2;
  localparam int O2M1_0_LSB       = 8;
  localparam int O2M2_0_LSB       = 7;
  localparam int O2M3_0_LSB       = 6;
  localparam int O2M1_1_LSB       = 5;
  localparam int O2M2_1_LSB       = 4;
  localparam int O2M3_1_LSB       = 3;
  localparam int DQMUX1_LSB       = 2;
  localparam int DQMUX2_LSB       = 1;
  localparam int FLOPORLATCH_LSB  = 0;

  // Built field by field so the value stays tied to the layout above.
  // Evaluates to 37'h00_22C5_4038.
  localparam logic [CFG_W-1:0] RESET_FRAME =
      (CFG_W'(MEM_W'(16'h0116))     << MEM_LSB)         |
      (CFG_W'(SELECT_W'(2'b00))     << COMBOPTION_LSB)  |
      (CFG_W'(SELECT_W'(2'b10))     << MUX2_SELECT_LSB) |
      (CFG_W'(SELECT_W'(2'b10))     << MUX3_SELECT_LSB) |
      (CFG_W'(SELECT_W'(2'b10))     << MUX4_SELECT_LSB) |
      (CFG_W'(SELECT_W'(2'b00))     << MUX5_SELECT_LSB) |
      (CFG_W'(SELECT_W'(2'b00))     << MUX6_SELECT_LSB) |
      (CFG_W'(1'b0)                 << O2M1_0_LSB)      |
      (CFG_W'(1'b0)                 << O2M2_0_LSB)      |
      (CFG_W'(1'b0)                 << O2M3_0_LSB)      |
      (CFG_W'(1'b1)                 << O2M1_1_LSB)      |
      (CFG_W'(1'b1)                 << O2M2_1_LSB)      |
      (CFG_W'(1'b1)                 << O2M3_1_LSB)      |
      (CFG_W'(1'b0)                 << DQMUX1_LSB)      |
      (CFG_W'(1'b0)                 << DQMUX2_LSB)      |
      (CFG_W'(1'b0)                 << FLOPORLATCH_LSB);

endpackage

// File: rtl/clb_cfg_shifter.sv
// -----------------------------------------------------------------------------
// clb_cfg_shifter
// MSB-first serial-to-parallel shift register with a bit counter.
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   clear    empties the register and zeroes the counter (wins over shift)
//   shift    shift din in and advance the counter
//   din      serial input bit
//   shifted  register contents including the bit currently on din, i.e. the
//            value the register takes if this edge shifts
//   at_last  counter shows W-1 bits collected, so a shift now completes W bits
// -----------------------------------------------------------------------------
module clb_cfg_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift,
  input  logic         din,
  output logic [W-1:0] shifted,
  output logic         at_last
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  data;
  logic [CW-1:0] count;

  assign shifted = {data[W-2:0], din};
  assign at_last = (count == CW'(W - 1));

  // The counter is free running while shifting; the owner clears it at the
  // points where a new field starts, so wrapping in the sync hunt is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end else if (shift) begin
      data  <= shifted;
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/clb_config_loader.sv
// -----------------------------------------------------------------------------
// clb_config_loader
// Serial configuration controller for an array of CLB tiles. Hunts for a sync
// byte, checks the frame count byte, then shifts one frame per CLB into the
// register bank that drives the tiles.
//
// Optional feature macro: CLB_CFG_PARITY_EN
//   defined   - every frame carries a trailing even-parity bit; a bad frame is
//               dropped and the loader stops in ERROR
//   undefined - frames are CFG_W bits with no parity logic
//
// Ports:
//   K         clock, everything changes on posedge K
//   RST       asynchronous active-high reset
//   START     one-cycle pulse, begins or restarts a load from any state
//   DIN       serial configuration data, MSB first
//   DVALID    DIN is sampled only on edges where DVALID=1
//   CFG_DATA  flattened frame bank, slot i at [i*CFG_W +: CFG_W]
//   CFG_DONE  every frame loaded and accepted
//   CFG_ERR   length mismatch or parity failure
//   BUSY      loader is in HUNT, LEN or FRAME
// -----------------------------------------------------------------------------
module clb_config_loader
  import clb_cfg_pkg::*;
#(
  parameter int         NUM_CLB   = 4,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic                     K,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     DIN,
  input  logic                     DVALID,
  output logic [NUM_CLB*CFG_W-1:0] CFG_DATA,
  output logic                     CFG_DONE,
  output logic                     CFG_ERR,
  output logic                     BUSY
);

`ifdef CLB_CFG_PARITY_EN
  localparam int FRAME_BITS = CFG_W + 1;
`else
  localparam int FRAME_BITS = CFG_W;
`endif

  localparam int              IW        = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_CLB - 1);
  localparam logic [7:0]      LEN_VALUE = 8'(NUM_CLB);

  cfg_state_t state_q, state_d;

  logic                  win_clear, win_shift, win_last;
  logic [7:0]            win_shifted;
  logic                  frm_clear, frm_shift, frm_last;
  logic [FRAME_BITS-1:0] frm_shifted;
  logic [CFG_W-1:0]      frame_word;
  logic                  frame_ok;

  logic [IW-1:0]         frame_idx;
  logic                  idx_clear, idx_inc;
  logic                  commit;
  logic                  flags_clear, done_set, err_set;

  logic [CFG_W-1:0]      bank [NUM_CLB];

  // One 8-bit shifter serves as the sync window in HUNT and as the length
  // collector in LEN; the second one assembles frames.
  clb_cfg_shifter #(.W(8)) u_win (
    .clk     (K),
    .rst     (RST),
    .clear   (win_clear),
    .shift   (win_shift),
    .din     (DIN),
    .shifted (win_shifted),
    .at_last (win_last)
  );

  clb_cfg_shifter #(.W(FRAME_BITS)) u_frm (
    .clk     (K),
    .rst     (RST),
    .clear   (frm_clear),
    .shift   (frm_shift),
    .din     (DIN),
    .shifted (frm_shifted),
    .at_last (frm_last)
  );

  // Payload and acceptance of the frame completing on this edge. Even parity
  // means the frame including its parity bit has an even number of ones.
`ifdef CLB_CFG_PARITY_EN
  assign frame_word = frm_shifted[FRAME_BITS-1:1];
  assign frame_ok   = ~(^frm_shifted);
`else
  assign frame_word = frm_shifted;
  assign frame_ok   = 1'b1;
`endif

  always_ff @(posedge K or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls. START overrides everything, including a
  // valid bit on the same edge, which is therefore dropped. Without DVALID
  // nothing shifts or advances.
  always_comb begin
    state_d     = state_q;
    win_clear   = 1'b0;
    win_shift   = 1'b0;
    frm_clear   = 1'b0;
    frm_shift   = 1'b0;
    commit      = 1'b0;
    idx_clear   = 1'b0;
    idx_inc     = 1'b0;
    flags_clear = 1'b0;
    done_set    = 1'b0;
    err_set     = 1'b0;

    if (START) begin
      state_d     = ST_HUNT;
      win_clear   = 1'b1;
      frm_clear   = 1'b1;
      idx_clear   = 1'b1;
      flags_clear = 1'b1;
    end else if (DVALID) begin
      case (state_q)
        ST_HUNT: begin
          win_shift = 1'b1;
          // Sliding window, so a sync word overlapping discarded bits is
          // still found.
          if (win_shifted == SYNC_WORD) begin
            state_d   = ST_LEN;
            win_clear = 1'b1;
          end
        end
        ST_LEN: begin
          win_shift = 1'b1;
          if (win_last) begin
            win_clear = 1'b1;
            if (win_shifted == LEN_VALUE) begin
              state_d = ST_FRAME;
            end else begin
              state_d = ST_ERROR;
              err_set = 1'b1;
            end
          end
        end
        ST_FRAME: begin
          frm_shift = 1'b1;
          if (frm_last) begin
            frm_clear = 1'b1;
            if (!frame_ok) begin
              state_d = ST_ERROR;
              err_set = 1'b1;
            end else begin
              commit = 1'b1;
              if (frame_idx == LAST_IDX) begin
                state_d  = ST_DONE;
                done_set = 1'b1;
              end else begin
                idx_inc = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Slot pointer; it stops at the last slot because the FSM leaves FRAME there.
  always_ff @(posedge K or posedge RST) begin
    if (RST) begin
      frame_idx <= '0;
    end else if (idx_clear) begin
      frame_idx <= '0;
    end else if (idx_inc) begin
      frame_idx <= frame_idx + IW'(1);
    end
  end

  // Status flags are registered so they rise on the same edge as the state.
  always_ff @(posedge K or posedge RST) begin
    if (RST) begin
      CFG_DONE <= 1'b0;
      CFG_ERR  <= 1'b0;
    end else if (flags_clear) begin
      CFG_DONE <= 1'b0;
      CFG_ERR  <= 1'b0;
    end else begin
      if (done_set) begin
        CFG_DONE <= 1'b1;
      end
      if (err_set) begin
        CFG_ERR <= 1'b1;
      end
    end
  end

  // Frame bank. Reset restores every tile to its default configuration;
  // START leaves the old contents in place until new frames overwrite them.
  always_ff @(posedge K or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CLB; i++) begin
        bank[i] <= RESET_FRAME;
      end
    end else if (commit) begin
      bank[frame_idx] <= frame_word;
    end
  end

  for (genvar g = 0; g < NUM_CLB; g++) begin : g_slot
    assign CFG_DATA[g*CFG_W +: CFG_W] = bank[g];
  end

  assign BUSY = (state_q == ST_HUNT) || (state_q == ST_LEN) || (state_q == ST_FRAME);

endmodule
